adc_sample_arbiter: RTL and testbench

// - Merges the four AD7673 reader result streams into one pixel-ordered stream for the host link FIFO.
// - Samples arrive per-channel in the sensor's interleaved order; the block buffers each channel and emits

---
 rtl/adc_sample_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_adc_sample_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_arbiter
// Brief    : Buffers four ADC result streams and emits them as one stream in
//            pixel order (SOF/EOF tagged). Define ADC_ARB_TIMESTAMP_EN to add
//            out_timestamp, the free-running cycle count at each sample's push.
// Revision : 1.0  initial release
// ============================================================================
module adc_sample_arbiter #(
  parameter int DATA_W   = 16,
  parameter int PIXELS   = 128,
  parameter int CH_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [3:0]          adc_valid,
  input  logic [4*DATA_W-1:0] adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [6:0]          out_pixel,
  output logic                out_sof,
  output logic                out_eof,
  output logic [3:0]          overflow,
  output logic                frame_error,
  output logic [15:0]         frame_count,
`ifdef ADC_ARB_TIMESTAMP_EN
  output logic [31:0]         out_timestamp,
`endif
  output logic                busy
);

  localparam int PIX_W = 7;
  localparam int PTR_W = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
`ifdef ADC_ARB_TIMESTAMP_EN
  localparam int TS_W  = 32;
  localparam int ENT_W = DATA_W + TS_W;
`else
  localparam int ENT_W = DATA_W;
`endif
  localparam logic [PIX_W-1:0] C_LAST_PIXEL = PIX_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(CH_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PIX_W-1:0]   r_next_pixel;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [PIX_W-1:0]   r_out_pixel;
  logic               r_out_sof;
  logic               r_out_eof;
  logic [3:0]         r_overflow;
  logic               r_frame_error;
  logic [15:0]        r_frame_count;

  logic [3:0]         w_avail;
  logic [3:0]         w_pop;
  logic [3:0]         w_drop;
  logic [ENT_W-1:0]   w_entry_in [4];
  logic [ENT_W-1:0]   w_head [4];
  logic [ENT_W-1:0]   w_sel_head;
  logic [1:0]         w_exp_ch;
  logic               w_out_free;
  logic               w_pop_any;
  logic               w_xfer;
  logic               w_last_pop;
  logic               w_frame_done;

  // Sensor interleave: pixel p mod 4 is read out by ADC2, ADC4, ADC1, ADC3
  always_comb begin
    w_exp_ch = 2'd1;
    case (r_next_pixel[1:0])
      2'd0:    w_exp_ch = 2'd1;
      2'd1:    w_exp_ch = 2'd3;
      2'd2:    w_exp_ch = 2'd0;
      default: w_exp_ch = 2'd2;
    endcase
  end

  assign w_out_free = !r_out_valid || out_ready;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_pop_any  = (r_state == ST_COLLECT) && !frame_start && w_out_free && w_avail[w_exp_ch];
  assign w_last_pop = w_pop_any && (r_next_pixel == C_LAST_PIXEL);
  assign w_sel_head = w_head[w_exp_ch];

`ifdef ADC_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_out_timestamp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_timestamp <= '0;
    end else if (!frame_start && w_pop_any) begin
      r_out_timestamp <= w_sel_head[ENT_W-1 -: TS_W];
    end
  end

  assign out_timestamp = r_out_timestamp;
`endif

  // Per-channel buffers. An empty buffer passes the incoming sample straight
  // through when it is the one being popped, giving single-cycle latency.
  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [ENT_W-1:0] r_mem [CH_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_bypass;
    logic             w_write;
    logic             w_read;

`ifdef ADC_ARB_TIMESTAMP_EN
    assign w_entry_in[c] = {r_ts_cnt, adc_data[c*DATA_W +: DATA_W]};
`else
    assign w_entry_in[c] = adc_data[c*DATA_W +: DATA_W];
`endif

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    assign w_avail[c] = !w_empty || adc_valid[c];
    assign w_pop[c]   = w_pop_any && (w_exp_ch == 2'(c));
    assign w_bypass   = w_pop[c] && w_empty;
    assign w_push     = adc_valid[c] && (frame_start || !w_full || w_pop[c]);
    assign w_write    = w_push && !w_bypass;
    assign w_read     = w_pop[c] && !w_empty;
    assign w_head[c]  = w_empty ? w_entry_in[c] : r_mem[r_rd_ptr];
    assign w_drop[c]  = adc_valid[c] && !w_push && (r_state != ST_IDLE);
    assign w_wr_idx   = frame_start ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (frame_start) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= w_write ? PTR_W'(1) : '0;
        r_count  <= w_write ? CNT_W'(1) : '0;
      end else begin
        if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_read)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_read);
      end
    end

    always_ff @(posedge clk) begin
      if (w_write) r_mem[w_wr_idx] <= w_entry_in[c];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (frame_start)     w_state_nxt = ST_COLLECT;
        else if (w_last_pop) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (frame_start) begin
          w_state_nxt = ST_COLLECT;
        end else if (w_xfer) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_next_pixel  <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_pixel   <= '0;
      r_out_sof     <= 1'b0;
      r_out_eof     <= 1'b0;
      r_overflow    <= '0;
      r_frame_error <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= r_overflow | w_drop;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      // A restart abandons the frame in flight, including an unaccepted output
      if (frame_start) begin
        r_next_pixel <= '0;
        r_out_valid  <= 1'b0;
        if (r_state != ST_IDLE) r_frame_error <= 1'b1;
      end else if (w_pop_any) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_sel_head[DATA_W-1:0];
        r_out_pixel  <= r_next_pixel;
        r_out_sof    <= (r_next_pixel == '0);
        r_out_eof    <= (r_next_pixel == C_LAST_PIXEL);
        r_next_pixel <= r_next_pixel + PIX_W'(1);
      end else if (w_xfer) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_pixel   = r_out_pixel;
  assign out_sof     = r_out_sof;
  assign out_eof     = r_out_eof;
  assign overflow    = r_overflow;
  assign frame_error = r_frame_error;
  assign frame_count = r_frame_count;
  assign busy        = (r_state == ST_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_arbiter.sv
`default_nettype none
// Bench for adc_sample_arbiter: queue-level reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_adc_sample_arbiter;
  localparam int DATA_W   = 16;
  localparam int PIXELS   = 128;
  localparam int CH_DEPTH = 2;
  localparam int MAP [4]  = '{1, 3, 0, 2};

  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_DONE = 2;

  logic        clk = 1'b0;
  logic        reset, frame_start, out_ready;
  logic [3:0]  adc_valid;
  logic [63:0] adc_data;
  logic        out_valid, out_sof, out_eof, frame_error, busy;
  logic [15:0] out_data, frame_count;
  logic [6:0]  out_pixel;
  logic [3:0]  overflow;
`ifdef ADC_ARB_TIMESTAMP_EN
  logic [31:0] out_timestamp;
`endif

  adc_sample_arbiter #(.DATA_W(DATA_W), .PIXELS(PIXELS), .CH_DEPTH(CH_DEPTH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pixel(out_pixel), .out_sof(out_sof), .out_eof(out_eof),
    .overflow(overflow), .frame_error(frame_error), .frame_count(frame_count),
`ifdef ADC_ARB_TIMESTAMP_EN
    .out_timestamp(out_timestamp),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] d; logic [31:0] ts; } ent_t;
  typedef struct { int pix; logic [15:0] d; logic sof; logic eof; } xf_t;

  ent_t        q [4][$];
  xf_t         xlog [$];
  logic        m_ov;
  logic [15:0] m_data, m_fc;
  logic [31:0] m_ts, m_tsout;
  int          m_pix, m_next, m_phase;
  logic [3:0]  m_ovf;
  logic        m_ferr;

  function automatic ent_t mk(input int c);
    ent_t e;
    e.d  = 16'(adc_data >> (c * 16));
    e.ts = m_ts;
    return e;
  endfunction

  always @(posedge clk) begin
    logic xfer;
    logic can_pop;
    int   ch;
    ent_t e;
    if (reset) begin
      for (int c = 0; c < 4; c++) q[c].delete();
      m_ov = 0; m_data = 0; m_pix = 0; m_next = 0; m_phase = PH_IDLE;
      m_ovf = 0; m_ferr = 0; m_fc = 0; m_ts = 0; m_tsout = 0;
    end else begin
      if (out_valid && out_ready) begin
        xf_t x;
        x.pix = int'(out_pixel); x.d = out_data; x.sof = out_sof; x.eof = out_eof;
        xlog.push_back(x);
      end
      xfer = m_ov && out_ready;
      if (frame_start) begin
        if (m_phase != PH_IDLE) m_ferr = 1;
        m_ov = 0; m_next = 0; m_phase = PH_COLLECT;
        for (int c = 0; c < 4; c++) begin
          q[c].delete();
          if (adc_valid[c]) q[c].push_back(mk(c));
        end
      end else begin
        ch      = MAP[m_next % 4];
        can_pop = (m_phase == PH_COLLECT) && (!m_ov || out_ready);
        for (int c = 0; c < 4; c++) begin
          if (adc_valid[c]) begin
            if (q[c].size() < CH_DEPTH || (can_pop && ch == c)) q[c].push_back(mk(c));
            else if (m_phase != PH_IDLE) m_ovf[c] = 1;
          end
        end
        if (xfer) m_ov = 0;
        if (can_pop && q[ch].size() != 0) begin
          e = q[ch].pop_front();
          m_ov = 1; m_data = e.d; m_tsout = e.ts; m_pix = m_next; m_next++;
          if (m_pix == PIXELS - 1) m_phase = PH_DONE;
        end else if (m_phase == PH_DONE && xfer) begin
          m_fc = m_fc + 16'd1;
          m_phase = PH_IDLE;
        end
      end
      m_ts = m_ts + 32'd1;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, m_phase == PH_COLLECT);
    chk("overflow", overflow, m_ovf);
    chk("frame_error", frame_error, m_ferr);
    chk("frame_count", frame_count, m_fc);
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_pixel", out_pixel, m_pix);
      chk("out_sof", out_sof, m_pix == 0);
      chk("out_eof", out_eof, m_pix == PIXELS - 1);
`ifdef ADC_ARB_TIMESTAMP_EN
      chk("out_timestamp", out_timestamp, m_tsout);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pix(input int p, input logic [15:0] d, input logic fs = 1'b0);
    @(negedge clk);
    frame_start = fs;
    adc_valid   = 4'b0001 << MAP[p % 4];
    adc_data    = 64'(d) << (MAP[p % 4] * 16);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 0;
      adc_valid   = 0;
      adc_data    = 0;
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1;
    adc_valid   = 0;
    xlog.delete();
  endtask

  task automatic check_frame(input string nm, input logic [15:0] base);
    int bad = 0;
    chk({nm, " xfer count"}, xlog.size(), PIXELS);
    foreach (xlog[i]) begin
      if (xlog[i].pix != i || xlog[i].d != base + 16'(i)) bad++;
    end
    chk({nm, " order/data errors"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1; frame_start = 0; adc_valid = 0; adc_data = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_pixel", out_pixel, 0);
    chk("rst sof/eof", {out_sof, out_eof}, 0);
    chk("rst overflow", overflow, 0);
    chk("rst frame_error", frame_error, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst busy", busy, 0);
    reset = 0;
    idle(2);

    // Frame 1: samples arrive in readout order ch1,ch3,ch0,ch2
    pulse_fs();
    for (int p = 0; p < PIXELS; p++) send_pix(p, 16'h1000 + 16'(p));
    idle(5);
    check_frame("f1", 16'h1000);
    chk("f1 first sof", xlog[0].sof, 1);
    chk("f1 last eof", xlog[PIXELS-1].eof, 1);
    chk("f1 frame_count", frame_count, 1);
    chk("f1 overflow", overflow, 0);
    chk("f1 busy", busy, 0);

    // Frame 2: ch0 (pixel 2) arrives before ch1 (pixel 0)
    pulse_fs();
    send_pix(2, 16'hA002);
    send_pix(0, 16'hA000);
    @(posedge clk); #1;
    chk("latency out_valid", out_valid, 1);
    chk("latency out_pixel", out_pixel, 0);
    send_pix(1, 16'hA001);
    send_pix(3, 16'hA003);
    for (int p = 4; p < PIXELS; p++) send_pix(p, 16'hA000 + 16'(p));
    idle(5);
    check_frame("f2", 16'hA000);
    chk("f2 pix0 data", xlog[0].d, 16'hA000);
    chk("f2 pix2 data", xlog[2].d, 16'hA002);
    chk("f2 frame_count", frame_count, 2);

    // Frame 3: stall 20 cycles while ch1 receives three extra samples
    pulse_fs();
    out_ready = 0;
    send_pix(0, 16'hB000);
    send_pix(4, 16'hB104);
    send_pix(8, 16'hB108);
    send_pix(12, 16'hB10C);
    idle(16);
    chk("stall overflow", overflow, 4'b0010);
    chk("stall held valid", out_valid, 1);
    chk("stall held pixel", out_pixel, 0);
    chk("stall held data", out_data, 16'hB000);
    out_ready = 1;
    for (int p = 1; p < PIXELS; p++)
      if (p != 4 && p != 8) send_pix(p, 16'hB000 + 16'(p));
    idle(5);
    chk("f3 xfer count", xlog.size(), PIXELS);
    bad = 0;
    foreach (xlog[i]) if (xlog[i].pix != i) bad++;
    chk("f3 pixel order errors", bad, 0);
    chk("f3 pix4 data", xlog[4].d, 16'hB104);
    chk("f3 pix8 data", xlog[8].d, 16'hB108);
    chk("f3 pix12 data", xlog[12].d, 16'hB00C);
    chk("f3 frame_count", frame_count, 3);
    chk("f3 overflow sticky", overflow, 4'b0010);

    // Frame 4: restart at pixel 60, sample for new pixel 0 in the same cycle
    pulse_fs();
    for (int p = 0; p < 60; p++) send_pix(p, 16'hC000 + 16'(p));
    idle(3);
    xlog.delete();
    send_pix(0, 16'hD000, 1'b1);
    @(posedge clk); #1;
    chk("restart out_valid", out_valid, 0);
    chk("restart frame_error", frame_error, 1);
    chk("restart frame_count", frame_count, 3);
    for (int p = 1; p < PIXELS; p++) send_pix(p, 16'hD000 + 16'(p));
    idle(5);
    check_frame("f4", 16'hD000);
    chk("f4 sof after restart", xlog[0].sof, 1);
    chk("f4 frame_count", frame_count, 4);

    // Frame 5: counter preset to 0xFFFF must wrap to 0
    @(negedge clk);
    dut.r_frame_count = 16'hFFFF;
    m_fc = 16'hFFFF;
    pulse_fs();
    for (int p = 0; p < PIXELS; p++) send_pix(p, 16'h5000 + 16'(p));
    idle(5);
    check_frame("f5", 16'h5000);
    chk("wrap frame_count", frame_count, 0);
    chk("wrap frame_error sticky", frame_error, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
